// File: rtl/uart_telemetry_tx.sv
// uart_telemetry_tx: packs a channel-tagged rpm sample into a 4-byte report frame and sends it as 8N1.
// Define UART_TX_SAT_EN to clamp samples to the 13-bit range instead of truncating them.
module uart_telemetry_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CHN    = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         tm_valid_i,
  input  logic [2:0]                   tm_chn_i,
  input  logic signed [DATA_WIDTH-1:0] tm_data_i,
  output logic                         tm_ready_o,
  output logic                         uart_tx,
  output logic                         busy_o
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [2:0] CHN_LIM = 3'(NUM_CHN);
  typedef enum logic [2:0] {INIT, IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [CW-1:0] baud_cnt;
  logic [2:0] bit_cnt, next_bit;
  logic [1:0] byte_idx;
  logic [2:0] chn_q;
  logic [12:0] d_q, d_enc;
  logic [7:0] cur_byte;
  logic baud_last;
`ifdef UART_TX_SAT_EN
  localparam logic signed [DATA_WIDTH-1:0] SMAX = DATA_WIDTH'(4095);
  localparam logic signed [DATA_WIDTH-1:0] SMIN = DATA_WIDTH'(-4096);
  always_comb d_enc = (tm_data_i > SMAX) ? 13'h0fff : (tm_data_i < SMIN) ? 13'h1000 : tm_data_i[12:0];
`else
  logic unused_hi;
  assign unused_hi = ^tm_data_i;
  always_comb d_enc = tm_data_i[12:0];
`endif
  always_comb begin
    cur_byte = byte_idx == 2'd0 ? 8'h92 : byte_idx == 2'd1 ? {chn_q, d_q[12:8]} : byte_idx == 2'd2 ? d_q[7:0] : 8'hff;
    baud_last = baud_cnt == BAUD_LAST;
    next_bit = bit_cnt + 3'd1;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= INIT;
      uart_tx <= 1'b1;
      tm_ready_o <= 1'b0;
      busy_o <= 1'b0;
      baud_cnt <= '0;
      bit_cnt <= '0;
      byte_idx <= '0;
      chn_q <= '0;
      d_q <= '0;
    end else begin
      case (state)
        INIT: begin
          state <= IDLE;
          tm_ready_o <= 1'b1;
        end
        IDLE: if (tm_valid_i && tm_chn_i < CHN_LIM) begin
          chn_q <= tm_chn_i;
          d_q <= d_enc;
          state <= START;
          uart_tx <= 1'b0;
          busy_o <= 1'b1;
          tm_ready_o <= 1'b0;
          byte_idx <= '0;
          baud_cnt <= '0;
        end
        START: if (baud_last) begin
          baud_cnt <= '0;
          bit_cnt <= '0;
          state <= DATA;
          uart_tx <= cur_byte[0];
        end else baud_cnt <= baud_cnt + 1'b1;
        DATA: if (baud_last) begin
          baud_cnt <= '0;
          if (bit_cnt == 3'd7) begin
            bit_cnt <= '0;
            state <= STOP;
            uart_tx <= 1'b1;
          end else begin
            bit_cnt <= next_bit;
            uart_tx <= cur_byte[next_bit];
          end
        end else baud_cnt <= baud_cnt + 1'b1;
        STOP: if (baud_last) begin
          baud_cnt <= '0;
          if (byte_idx != 2'd3) begin
            byte_idx <= byte_idx + 2'd1;
            state <= START;
            uart_tx <= 1'b0;
          end else begin
            byte_idx <= '0;
            state <= IDLE;
            busy_o <= 1'b0;
            tm_ready_o <= 1'b1;
          end
        end else baud_cnt <= baud_cnt + 1'b1;
        default: state <= INIT;
      endcase
    end
endmodule

// File: tb/tb_uart_telemetry_tx.sv
// tb_uart_telemetry_tx: cycle-exact frame model plus a mid-bit line receiver checked against literal frames.
module tb_uart_telemetry_tx;
  localparam int BD = 10;
  localparam int NCH = 4;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic tm_valid_i = 1'b0;
  logic [2:0] tm_chn_i = '0;
  logic signed [15:0] tm_data_i = '0;
  logic tm_ready_o, uart_tx, busy_o;
  int n_vec = 0, n_err = 0, cyc = 0;
  logic chk_en = 1'b0;

  uart_telemetry_tx #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_WIDTH(16), .NUM_CHN(NCH)) dut (
    .clk(clk), .rstn(rstn), .tm_valid_i(tm_valid_i), .tm_chn_i(tm_chn_i), .tm_data_i(tm_data_i),
    .tm_ready_o(tm_ready_o), .uart_tx(uart_tx), .busy_o(busy_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Line bits of a whole frame: per byte a 0 start bit, 8 data bits LSB first, a 1 stop bit.
  function automatic logic [39:0] frame_bits(input logic [2:0] c, input logic signed [15:0] v);
    int x;
    logic [31:0] u;
    logic [7:0] b [4];
    logic [39:0] r;
    x = int'(v);
`ifdef UART_TX_SAT_EN
    if (x > 4095) x = 4095;
    if (x < -4096) x = -4096;
`endif
    u = x;
    b[0] = 8'h92;
    b[1] = {c, u[12:8]};
    b[2] = u[7:0];
    b[3] = 8'hff;
    for (int i = 0; i < 4; i++) begin
      r[i*10] = 1'b0;
      for (int j = 0; j < 8; j++) r[i*10+1+j] = b[i][j];
      r[i*10+9] = 1'b1;
    end
    return r;
  endfunction

  int m_pos = -1;
  logic m_init = 1'b1;
  logic [39:0] m_bits = '0;
  logic exp_tx, exp_busy, exp_ready;

  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      m_pos <= -1;
      m_init <= 1'b1;
    end else if (m_init) m_init <= 1'b0;
    else if (m_pos >= 0) m_pos <= (m_pos == 40*BD-1) ? -1 : m_pos + 1;
    else if (tm_valid_i && tm_chn_i < 3'(NCH)) begin
      m_pos <= 0;
      m_bits <= frame_bits(tm_chn_i, tm_data_i);
    end

  assign exp_busy = m_pos >= 0;
  assign exp_ready = m_pos < 0 && !m_init;
  assign exp_tx = m_pos < 0 ? 1'b1 : m_bits[m_pos/BD];

  always @(negedge clk)
    if (chk_en) begin
      check("tx", {31'b0, uart_tx}, {31'b0, exp_tx});
      check("busy", {31'b0, busy_o}, {31'b0, exp_busy});
      check("ready", {31'b0, tm_ready_o}, {31'b0, exp_ready});
    end

  task automatic send(input logic [2:0] c, input int v);
    tm_chn_i = c;
    tm_data_i = 16'(v);
    tm_valid_i = 1'b1;
    @(negedge clk);
    tm_valid_i = 1'b0;
  endtask

  task automatic frame(input string nm, input logic [31:0] expb, output int s);
    int k;
    logic [39:0] r;
    k = 0;
    while (uart_tx !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_start_seen"}, {31'b0, k < 50}, 32'd1);
    s = cyc;
    repeat (BD/2) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      r[i] = uart_tx;
      if (i < 39) repeat (BD) @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_byte%0d", nm, i), {24'b0, r[i*10+1 +: 8]}, {24'b0, expb[31-8*i -: 8]});
      check($sformatf("%s_frame%0d", nm, i), {30'b0, r[i*10], r[i*10+9]}, 32'd1);
    end
    k = 0;
    while (tm_ready_o !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_ready_at"}, cyc - s, 40*BD);
  endtask

  initial begin
    int s1, s2, lows, nready;
    #1 rstn = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    rstn = 1'b1;
    #1 check("init_ready", {31'b0, tm_ready_o}, 32'd0);
    @(negedge clk);
    check("ready_after_init", {31'b0, tm_ready_o}, 32'd1);
    repeat (30) @(negedge clk);
    send(3'd1, 1500);
    frame("f1", 32'h9225DCFF, s1);
    send(3'd2, -300);
    frame("f2", 32'h925ED4FF, s1);
    send(3'd0, 5000);
`ifdef UART_TX_SAT_EN
    frame("f3", 32'h920FFFFF, s1);
`else
    frame("f3", 32'h921388FF, s1);
`endif
    send(3'd5, 100);
    lows = 0;
    nready = 0;
    repeat (500) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
      if (tm_ready_o !== 1'b1) nready++;
    end
    check("bad_chn_no_start", lows, 0);
    check("bad_chn_ready", nready, 0);
    tm_chn_i = 3'd1;
    tm_data_i = 16'sd1500;
    tm_valid_i = 1'b1;
    @(negedge clk);
    tm_chn_i = 3'd2;
    tm_data_i = -16'sd300;
    frame("held1", 32'h9225DCFF, s1);
    lows = 0;
    while (uart_tx !== 1'b0 && lows < 50) begin
      @(negedge clk);
      lows++;
    end
    s2 = cyc;
    tm_valid_i = 1'b0;
    check("held_gap", s2 - s1, 40*BD + 1);
    frame("held2", 32'h925ED4FF, s1);
    repeat (5) @(negedge clk);
    send(3'd1, 1500);
    repeat (245) @(negedge clk);
    #2 rstn = 1'b0;
    #1 check("async_rst_tx", {31'b0, uart_tx}, 32'd1);
    check("async_rst_busy", {31'b0, busy_o}, 32'd0);
    check("async_rst_ready", {31'b0, tm_ready_o}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rerst_ready", {31'b0, tm_ready_o}, 32'd1);
    send(3'd3, 0);
    frame("f4", 32'h926000FF, s1);
    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end
endmodule

// File: doc/uart_telemetry_tx.md
# uart_telemetry_tx

Telemetry encoder and UART transmitter for the motor controller's return path. It accepts one measured-rpm sample per handshake, tagged with its channel. It packs the sample into the same 4-byte framing the command decoder uses, with its own header byte, and serialises it as 8N1 on `uart_tx`. It sits beside the command receiver and reports the PID loop's measured speed per channel to the host.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 115_200, line rate. `BAUD_DIV = CLK_FREQ / BAUD_RATE` (integer division), clocks per bit, must be ≥ 4.
- `DATA_WIDTH`, 16, sample width, two's complement.
- `NUM_CHN`, 4, number of valid channels, must be ≤ 4.

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `tm_valid_i`  in  1  sample valid.
- `tm_chn_i`  in  3  channel index.
- `tm_data_i`  in  `DATA_WIDTH`  signed rpm sample.
- `tm_ready_o`  out  1  block can accept a sample.
- `uart_tx`  out  1  serial line, idle high.
- `busy_o`  out  1  frame in progress.

## Operation
- Frame, in byte order:
  - `0x92`, the report_rpm header.
  - `{chn[2:0], d[12:8]}`.
  - `d[7:0]`.
  - `0xFF`, the terminator.
- `d` is the 13-bit encoded sample; the receiver sign-extends `d[12]`.
- A channel index below 4 keeps bits [7:5] of byte 1 away from `111`, so byte 1 can never equal `0xFF`.
- Handshake: a transfer occurs on any rising edge where `tm_valid_i && tm_ready_o`. Channel and data are captured in that cycle; the inputs are don't-care afterwards.
- Invalid channel (`tm_chn_i >= NUM_CHN`):
  - The sample is accepted and discarded.
  - No frame is sent.
  - `tm_ready_o` stays 1.
- Frame FSM states:
  - INIT: one cycle after reset, then IDLE.
  - IDLE: `tm_ready_o`=1. A valid transfer moves to START with byte index 0.
  - START: `uart_tx`=0 for `BAUD_DIV` clocks.
  - DATA: 8 bits, LSB first, `BAUD_DIV` clocks each.
  - STOP: `uart_tx`=1 for `BAUD_DIV` clocks. Then go to START with the next byte index if the index is below 3, otherwise go to IDLE.
- No idle gap is inserted between bytes within a frame.
- Counters:
  - Baud counter: 0..`BAUD_DIV`-1, wraps at the end of each bit.
  - Bit counter: 0..7.
  - Byte index: 0..3.
- `busy_o` = 1 in START, DATA and STOP.
- Valid samples presented while busy are not accepted (`tm_ready_o`=0). The block has no queue.

## Timing
- Reset values:
  - `uart_tx`=1.
  - `tm_ready_o`=0.
  - `busy_o`=0.
  - All counters 0.
- Reset is applied immediately and asynchronously, including mid-frame. After release: INIT for 1 cycle, then `tm_ready_o`=1.
- Acceptance edge at cycle T:
  - `uart_tx` falls (start bit) and `busy_o` rises in the cycle after T.
  - `tm_ready_o` falls in the same cycle.
- Frame duration is exactly 40·`BAUD_DIV` clocks, measured from the start-bit cycle to the last stop-bit cycle inclusive.
- `tm_ready_o` rises in the cycle after the last stop-bit cycle. A new frame can therefore begin 40·`BAUD_DIV`+1 clocks after the previous one began.
- All outputs are registered; there is no combinational path from inputs to `uart_tx`.

## Configuration
- `UART_TX_SAT_EN` defined:
  - Samples above 4095 encode as 4095 (`0x0FFF`).
  - Samples below −4096 encode as −4096 (`0x1000`).
- `UART_TX_SAT_EN` undefined: `d = tm_data_i[12:0]`, a plain truncation; wrap-around is permitted.
- In-range samples encode identically in both builds.

## Test plan
Bench settings: `CLK_FREQ`=50_000_000, `BAUD_RATE`=5_000_000, so `BAUD_DIV`=10.
- Reset release → `uart_tx`=1, `busy_o`=0, `tm_ready_o`=0 for 1 cycle then 1. Line stays idle with no input.
- chn 1, data 1500 → bytes `0x92 0x25 0xDC 0xFF`.
  - Each bit lasts exactly 10 clocks and bytes are back-to-back.
  - `busy_o` high for 400 clocks; `tm_ready_o` returns 1 at clock 401.
- chn 2, data −300 → `0x92 0x5E 0xD4 0xFF`.
- chn 0, data 5000:
  - With `UART_TX_SAT_EN` → `0x92 0x0F 0xFF 0xFF`.
  - Without → `0x92 0x13 0x88 0xFF`.
- chn 5, data 100 → no start bit within 500 clocks, `tm_ready_o` held 1.
  - A second valid sample held asserted during a frame is accepted only after the frame ends.
- `rstn` asserted during bit 3 of byte 2 → `uart_tx`=1 and `busy_o`=0 immediately.
  - After release, a new sample (chn 3, data 0) yields `0x92 0x60 0x00 0xFF`.
